decrypter_stream_ctrl: RTL and testbench
========================================

Name: decrypter_stream_ctrl

Overview:
Parametrised load/run/unload controller for the decrypter core. It replaces bench-driven byte poking with a valid/ready byte stream in and a valid/ready word stream out. It writes IN_BYTES bytes into the core input RAM, pulses the core start, waits for done, then reads OUT_WORDS result words and streams them out. It sits between the system bus/DMA and the decrypter, and handles back-to-back frames, timeout and abort.

Parameters:
IN_BYTES, 1984, bytes per ciphertext/secret-key frame loaded into the core
ADDR_W, 11, core input RAM address width; IN_BYTES <= 2^ADDR_W
OUT_WORDS, 8, result words per frame
OUT_W, 32, result word width
OADDR_W, 3, core output address width; OUT_WORDS <= 2^OADDR_W
RD_LAT, 1, core output read latency in cycles (1..3)
TIMEOUT, 0, max cycles waiting for core_done; 0 disables the timeout

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
s_data  in  8  input byte stream
s_valid  in  1  input byte valid
s_ready  out  1  controller accepts a byte this cycle
m_data  out  OUT_W  result word
m_valid  out  1  result word valid
m_ready  in  1  downstream accepts the word
m_last  out  1  marks word OUT_WORDS-1 of a frame
abort  in  1  drop the current frame, return to IDLE
core_rst  out  1  active-high reset pulse to the core
core_start  out  1  one-cycle start pulse to the core
core_done  in  1  core completion, level
core_dia  out  8  core input RAM write data
core_wea  out  1  core input RAM write enable
core_addra  out  ADDR_W  core input RAM write address
core_oaddr  out  OADDR_W  core output read address
core_odo  in  OUT_W  core output read data
busy  out  1  high in any state other than IDLE
timeout_err  out  1  sticky; set on timeout, cleared by reset only
frame_cnt  out  16  completed frames, wraps at 2^16

Behaviour:
- Reset (rst=0 at edge): state=IDLE. All outputs 0 except core_rst=1. Counters 0. timeout_err=0.
- States: IDLE, LOAD, CRST, START, WAIT, READ, OUT.
- IDLE:
  - s_ready=1.
  - On the first s_valid, that byte is written (core_wea=1, core_addra=0) in the same cycle, and the state moves to LOAD.
- LOAD:
  - s_ready=1.
  - Each s_valid&s_ready cycle drives core_wea=1, core_dia=s_data, core_addra=byte index, and increments the index.
  - A cycle with no s_valid drives core_wea=0.
  - On the byte at index IN_BYTES-1 -> CRST. s_ready drops the next cycle, so no byte beyond the frame is accepted.
- CRST: core_rst=1 for exactly one cycle -> START.
- START: core_start=1 for exactly one cycle; clears the wait counter -> WAIT.
- WAIT:
  - core_done=1 -> READ with word index 0.
  - If TIMEOUT>0 and the wait counter reaches TIMEOUT: set timeout_err -> IDLE. No output is produced and frame_cnt is unchanged.
- READ: drive core_oaddr=word index, hold it RD_LAT cycles, capture core_odo into the m_data register -> OUT.
- OUT:
  - m_valid=1; m_data and m_last stay stable until m_ready.
  - On m_valid&m_ready, if index<OUT_WORDS-1: index+1 -> READ.
  - Otherwise frame_cnt+1 -> IDLE.
  - Minimum cadence is one word per RD_LAT+1 cycles.
- abort=1 in any non-IDLE state -> IDLE next cycle:
  - m_valid drops and any partial frame is discarded.
  - The next frame restarts at address 0.
  - abort has priority over all other transitions.
- Back-to-back: a byte offered in the cycle the state returns to IDLE is accepted as byte 0 of the next frame.
- core_wea is never asserted outside IDLE/LOAD. core_start is never asserted without a full load since the last IDLE.
- Reset asserted mid-frame: immediate return to the reset state. Partial data is lost and no outputs are glitched beyond the reset values.

Test Plan:
- Single frame: stream bytes 0..IN_BYTES-1 with s_valid always 1 and a core model with done after 500 cycles -> exactly 1984 writes at addresses 0..1983 with data = address mod 256; one core_rst pulse, then one core_start pulse; 8 words out matching the model, m_last only on word 7; frame_cnt=1.
- Backpressure: random s_valid gaps and m_ready held low for 20 cycles mid-unload -> no lost or duplicated bytes or words; m_data stable while m_valid&!m_ready.
- Back-to-back frames: 3 frames streamed without idle gaps -> frame_cnt=3, each output set correct, s_ready low from CRST until IDLE.
- Timeout: TIMEOUT=100 with core_done never asserted -> timeout_err=1 at cycle 100 after core_start; busy=0; no m_valid. The next frame completes normally with timeout_err still 1.
- Abort: abort after byte 1000 -> IDLE next cycle. A new full frame then writes from address 0 and completes correctly.
- Reset mid-unload: rst=0 during word 4 -> m_valid=0, busy=0, core_rst=1, frame_cnt=0 on the following cycle.

Source files
------------

// File: rtl/decrypter_stream_ctrl.sv
// ---------------------------------------------------------------------------
// decrypter_stream_ctrl
//
// Load/run/unload controller for the decrypter core.
//
// The controller takes a valid/ready byte stream, writes one frame of
// IN_BYTES bytes into the core input RAM, pulses core_rst and then
// core_start, and waits for core_done. It then reads OUT_WORDS result words
// from the core output port and presents them on a valid/ready word stream.
// Frames can follow back to back. An optional timeout abandons a frame whose
// core never finishes, and abort drops the current frame.
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   s_data/s_valid/s_ready         input byte stream
//   m_data/m_valid/m_ready/m_last  output word stream (m_last on final word)
//   abort             drop the current frame and return to idle
//   core_rst          active-high reset pulse to the core
//   core_start        one-cycle start pulse to the core
//   core_done         core completion level
//   core_dia/core_wea/core_addra   core input RAM write port
//   core_oaddr/core_odo            core output read port (RD_LAT latency)
//   busy              controller is not idle
//   timeout_err       sticky timeout flag, cleared only by reset
//   frame_cnt         completed frames, wraps at 2^16
// ---------------------------------------------------------------------------
module decrypter_stream_ctrl #(
  parameter int unsigned IN_BYTES  = 1984,
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned OUT_WORDS = 8,
  parameter int unsigned OUT_W     = 32,
  parameter int unsigned OADDR_W   = 3,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned TIMEOUT   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [OUT_W-1:0]   m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last,
  input  logic               abort,
  output logic               core_rst,
  output logic               core_start,
  input  logic               core_done,
  output logic [7:0]         core_dia,
  output logic               core_wea,
  output logic [ADDR_W-1:0]  core_addra,
  output logic [OADDR_W-1:0] core_oaddr,
  input  logic [OUT_W-1:0]   core_odo,
  output logic               busy,
  output logic               timeout_err,
  output logic [15:0]        frame_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CRST  = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4,
    ST_READ  = 3'd5,
    ST_OUT   = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0]  LAST_BYTE    = ADDR_W'(IN_BYTES - 1);
  localparam logic [OADDR_W-1:0] LAST_WORD    = OADDR_W'(OUT_WORDS - 1);
  localparam logic [1:0]         LAST_LAT     = 2'(RD_LAT - 1);
  localparam logic [31:0]        TIMEOUT_LAST = 32'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    byte_idx_q, byte_idx_d;
  logic [OADDR_W-1:0]   word_idx_q, word_idx_d;
  logic [OADDR_W-1:0]   oaddr_q, oaddr_d;
  logic [1:0]           lat_q, lat_d;
  logic [31:0]          wait_q, wait_d;
  logic [OUT_W-1:0]     m_data_q, m_data_d;
  logic                 m_last_q, m_last_d;
  logic                 timeout_err_q, timeout_err_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic                 m_valid_q;
  logic                 s_ready_q;
  logic                 busy_q;
  logic                 core_rst_q;
  logic                 core_start_q;

  logic                 accept_s;
  logic                 abort_s;
  logic                 wea_s;

  // Abort only matters once a frame is in progress.
  assign abort_s  = abort & (state_q != ST_IDLE);
  assign accept_s = s_valid & s_ready_q;
  // A byte handed over in the abort cycle is consumed but never written.
  assign wea_s    = accept_s & ~abort_s &
                    ((state_q == ST_IDLE) | (state_q == ST_LOAD));

  // Next-state and datapath decode for the frame sequencer.
  always_comb begin
    state_d       = state_q;
    byte_idx_d    = byte_idx_q;
    word_idx_d    = word_idx_q;
    oaddr_d       = oaddr_q;
    lat_d         = lat_q;
    wait_d        = wait_q;
    m_data_d      = m_data_q;
    m_last_d      = m_last_q;
    timeout_err_d = timeout_err_q;
    frame_cnt_d   = frame_cnt_q;

    case (state_q)
      ST_IDLE: begin
        // Byte 0 is written in the same cycle it is accepted.
        if (accept_s) begin
          if (LAST_BYTE == {ADDR_W{1'b0}}) begin
            byte_idx_d = {ADDR_W{1'b0}};
            state_d    = ST_CRST;
          end else begin
            byte_idx_d = ADDR_W'(1);
            state_d    = ST_LOAD;
          end
        end else begin
          byte_idx_d = {ADDR_W{1'b0}};
        end
      end

      ST_LOAD: begin
        if (accept_s) begin
          if (byte_idx_q == LAST_BYTE) begin
            byte_idx_d = {ADDR_W{1'b0}};
            state_d    = ST_CRST;
          end else begin
            byte_idx_d = byte_idx_q + ADDR_W'(1);
          end
        end else begin
          byte_idx_d = byte_idx_q;
        end
      end

      ST_CRST: begin
        state_d = ST_START;
      end

      ST_START: begin
        // Word 0 is addressed during the whole wait so its read data has
        // settled long before the first capture.
        wait_d     = 32'd0;
        word_idx_d = {OADDR_W{1'b0}};
        oaddr_d    = {OADDR_W{1'b0}};
        state_d    = ST_WAIT;
      end

      ST_WAIT: begin
        // The wait lasts at most TIMEOUT cycles; done wins in the last one.
        if (core_done) begin
          lat_d   = 2'd0;
          state_d = ST_READ;
        end else if ((TIMEOUT != 0) && (wait_q == TIMEOUT_LAST)) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end

      ST_READ: begin
        if (lat_q == LAST_LAT) begin
          m_data_d = core_odo;
          m_last_d = (word_idx_q == LAST_WORD);
          // Move the read address on to the next word straight away so the
          // core has the OUT cycle plus RD_LAT READ cycles to deliver it.
          if (word_idx_q == LAST_WORD) begin
            oaddr_d = {OADDR_W{1'b0}};
          end else begin
            oaddr_d = word_idx_q + OADDR_W'(1);
          end
          state_d = ST_OUT;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end

      ST_OUT: begin
        if (m_ready) begin
          if (m_last_q) begin
            m_last_d    = 1'b0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = ST_IDLE;
          end else begin
            word_idx_d = word_idx_q + OADDR_W'(1);
            lat_d      = 2'd0;
            state_d    = ST_READ;
          end
        end else begin
          state_d = ST_OUT;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort_s) begin
      state_d    = ST_IDLE;
      byte_idx_d = {ADDR_W{1'b0}};
      m_last_d   = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  // Sequencer state, counters and the captured result word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      byte_idx_q    <= {ADDR_W{1'b0}};
      word_idx_q    <= {OADDR_W{1'b0}};
      oaddr_q       <= {OADDR_W{1'b0}};
      lat_q         <= 2'd0;
      wait_q        <= 32'd0;
      m_data_q      <= {OUT_W{1'b0}};
      m_last_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      frame_cnt_q   <= 16'd0;
    end else begin
      state_q       <= state_d;
      byte_idx_q    <= byte_idx_d;
      word_idx_q    <= word_idx_d;
      oaddr_q       <= oaddr_d;
      lat_q         <= lat_d;
      wait_q        <= wait_d;
      m_data_q      <= m_data_d;
      m_last_q      <= m_last_d;
      timeout_err_q <= timeout_err_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  // Registered state-decoded control outputs; core_rst is held in reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s_ready_q    <= 1'b0;
      m_valid_q    <= 1'b0;
      busy_q       <= 1'b0;
      core_rst_q   <= 1'b1;
      core_start_q <= 1'b0;
    end else begin
      s_ready_q    <= (state_d == ST_IDLE) | (state_d == ST_LOAD);
      m_valid_q    <= (state_d == ST_OUT);
      busy_q       <= (state_d != ST_IDLE);
      core_rst_q   <= (state_d == ST_CRST);
      core_start_q <= (state_d == ST_START);
    end
  end

  assign s_ready     = s_ready_q;
  assign m_data      = m_data_q;
  assign m_valid     = m_valid_q;
  assign m_last      = m_last_q;
  assign core_rst    = core_rst_q;
  assign core_start  = core_start_q;
  assign core_wea    = wea_s;
  assign core_dia    = wea_s ? s_data : 8'd0;
  assign core_addra  = (state_q == ST_LOAD) ? byte_idx_q : {ADDR_W{1'b0}};
  assign core_oaddr  = oaddr_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_decrypter_stream_ctrl.sv
// ---------------------------------------------------------------------------
// tb_decrypter_stream_ctrl
//
// Self-checking bench for decrypter_stream_ctrl with a behavioural core:
// the core keeps the written input RAM, and on core_start hashes it into
// OUT_WORDS result words, raising core_done DONE_LAT cycles later. Expected
// RAM writes and result words are queued when stimulus is driven and popped
// when the controller produces them.
// ---------------------------------------------------------------------------
module tb_decrypter_stream_ctrl;

  localparam int IN_BYTES  = 1984;
  localparam int ADDR_W    = 11;
  localparam int OUT_WORDS = 8;
  localparam int OUT_W     = 32;
  localparam int OADDR_W   = 3;
  localparam int RD_LAT    = 2;
  localparam int TIMEOUT   = 100;
  localparam int DONE_LAT  = 60;

  logic               clk;
  logic               rst;
  logic [7:0]         s_data;
  logic               s_valid;
  logic               s_ready;
  logic [OUT_W-1:0]   m_data;
  logic               m_valid;
  logic               m_ready;
  logic               m_last;
  logic               abort;
  logic               core_rst;
  logic               core_start;
  logic               core_done;
  logic [7:0]         core_dia;
  logic               core_wea;
  logic [ADDR_W-1:0]  core_addra;
  logic [OADDR_W-1:0] core_oaddr;
  logic [OUT_W-1:0]   core_odo;
  logic               busy;
  logic               timeout_err;
  logic [15:0]        frame_cnt;

  decrypter_stream_ctrl #(
    .IN_BYTES (IN_BYTES), .ADDR_W (ADDR_W), .OUT_WORDS (OUT_WORDS),
    .OUT_W (OUT_W), .OADDR_W (OADDR_W), .RD_LAT (RD_LAT), .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk), .rst (rst),
    .s_data (s_data), .s_valid (s_valid), .s_ready (s_ready),
    .m_data (m_data), .m_valid (m_valid), .m_ready (m_ready), .m_last (m_last),
    .abort (abort),
    .core_rst (core_rst), .core_start (core_start), .core_done (core_done),
    .core_dia (core_dia), .core_wea (core_wea), .core_addra (core_addra),
    .core_oaddr (core_oaddr), .core_odo (core_odo),
    .busy (busy), .timeout_err (timeout_err), .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input int seed, input int i);
    return 8'((i + seed * 17) & 255);
  endfunction

  function automatic logic [31:0] exp_word(input int seed, input int w);
    logic [31:0] h;
    h = 32'h1505 + 32'(w);
    for (int j = w; j < IN_BYTES; j += OUT_WORDS) h = (h * 32'd33) ^ {24'd0, byte_of(seed, j)};
    return h;
  endfunction

  // ---------------- behavioural core ----------------
  logic [7:0]  ram      [IN_BYTES];
  logic [31:0] out_mem  [OUT_WORDS];
  logic [31:0] odo_pipe [RD_LAT];
  logic        running;
  int          done_cnt;
  logic        done_en;

  function automatic logic [31:0] hash_ram(input int w);
    logic [31:0] h;
    h = 32'h1505 + 32'(w);
    for (int j = w; j < IN_BYTES; j += OUT_WORDS) h = (h * 32'd33) ^ {24'd0, ram[j]};
    return h;
  endfunction

  assign core_odo = odo_pipe[RD_LAT-1];

  always @(posedge clk) begin
    if (core_wea) ram[core_addra] <= core_dia;
    odo_pipe[0] <= out_mem[core_oaddr];
    for (int k = 1; k < RD_LAT; k++) odo_pipe[k] <= odo_pipe[k-1];
    if (core_rst) begin
      running   <= 1'b0;
      core_done <= 1'b0;
    end else if (core_start) begin
      running   <= 1'b1;
      done_cnt  <= DONE_LAT;
      core_done <= 1'b0;
      for (int w = 0; w < OUT_WORDS; w++) out_mem[w] <= hash_ram(w);
    end else if (running && done_en) begin
      if (done_cnt <= 1) core_done <= 1'b1;
      else done_cnt <= done_cnt - 1;
    end
  end

  // ---------------- scoreboards and monitors ----------------
  logic [18:0] exp_wr [$];
  logic [32:0] exp_out [$];
  int          out_idx = 0;
  int          words_seen = 0;
  int          hold = 0;
  bit          stall_req = 1'b0;
  int          rst_p = 0;
  int          start_p = 0;

  // RAM write monitor
  initial forever begin
    @(negedge clk);
    if (rst && core_wea) begin
      if (exp_wr.size() == 0) check("wr_extra", 64'(exp_wr.size()), 64'd1);
      else check("wr", 64'({core_addra, core_dia}), 64'(exp_wr.pop_front()));
    end
  end

  // Output word monitor with stability check under backpressure
  initial begin
    bit          held_v;
    logic [32:0] held;
    held_v = 1'b0;
    held   = 33'd0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        out_idx = 0;
        held_v  = 1'b0;
      end else begin
        if (held_v && m_valid) check("m_stable", 64'({m_last, m_data}), 64'(held));
        if (m_valid && !m_ready) begin
          held_v = 1'b1;
          held   = {m_last, m_data};
        end else begin
          held_v = 1'b0;
        end
        if (m_valid && m_ready) begin
          if (exp_out.size() == 0) check("out_extra", 64'(exp_out.size()), 64'd1);
          else check($sformatf("out_w%0d", out_idx), 64'({m_last, m_data}), 64'(exp_out.pop_front()));
          out_idx = m_last ? 0 : out_idx + 1;
          words_seen++;
          if (stall_req && out_idx == 4) begin
            hold      = 20;
            stall_req = 1'b0;
          end
        end
      end
    end
  end

  // Core control pulse monitor
  initial begin
    logic prev_rst;
    prev_rst = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        rst_p    = 0;
        start_p  = 0;
        prev_rst = 1'b1;
      end else begin
        if (core_rst && !prev_rst) rst_p++;
        if (core_start) begin
          start_p++;
          check("start_after_rst", 64'(prev_rst), 64'd1);
        end
        if (core_rst || core_start || m_valid) check("srdy_low", 64'(s_ready), 64'd0);
        prev_rst = core_rst;
      end
    end
  end

  // Downstream ready driver
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold > 0) begin
        m_ready = 1'b0;
        hold--;
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_frame(input int seed, input int nbytes, input bit gaps, input bit expect_out);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < nbytes) begin
      @(posedge clk);
      #1;
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_data  = byte_of(seed, i);
        if (s_ready) begin
          exp_wr.push_back({ADDR_W'(i), byte_of(seed, i)});
          i++;
        end
      end
      guard++;
      if (guard > 20000) begin
        check("send_timeout", 64'(i), 64'(nbytes));
        i = nbytes;
      end
    end
    if (expect_out)
      for (int w = 0; w < OUT_WORDS; w++) exp_out.push_back({w == OUT_WORDS - 1, exp_word(seed, w)});
  endtask

  task automatic idle_in();
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int g;
    g = 0;
    while (frame_cnt != 16'(n) && g < 20000) begin
      @(negedge clk);
      g++;
    end
    check("frame_cnt", 64'(frame_cnt), 64'(n));
    check("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
    check("out_queue_empty", 64'(exp_out.size()), 64'd0);
  endtask

  initial begin
    int g;
    int ws;
    rst     = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'd0;
    abort   = 1'b0;
    done_en = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_core_rst", 64'(core_rst), 64'd1);
    check("rst_core_start", 64'(core_start), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_timeout_err", 64'(timeout_err), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Single frame, continuous input
    send_frame(0, IN_BYTES, 1'b0, 1'b1);
    idle_in();
    wait_frames(1);
    check("rst_pulses_1", 64'(rst_p), 64'd1);
    check("start_pulses_1", 64'(start_p), 64'd1);

    // Input gaps and a 20-cycle m_ready stall mid-unload
    stall_req = 1'b1;
    send_frame(1, IN_BYTES, 1'b1, 1'b1);
    idle_in();
    wait_frames(2);
    check("stall_applied", 64'(stall_req), 64'd0);

    // Three frames back to back
    send_frame(2, IN_BYTES, 1'b0, 1'b1);
    send_frame(3, IN_BYTES, 1'b0, 1'b1);
    send_frame(4, IN_BYTES, 1'b0, 1'b1);
    idle_in();
    wait_frames(5);

    // Timeout: core never completes
    done_en = 1'b0;
    ws = words_seen;
    send_frame(5, IN_BYTES, 1'b0, 1'b0);
    idle_in();
    g = 0;
    while (!core_start && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("to_start_seen", 64'(core_start), 64'd1);
    for (int k = 1; k <= TIMEOUT + 1; k++) begin
      @(negedge clk);
      if (k == TIMEOUT) begin
        check("to_busy_before", 64'(busy), 64'd1);
        check("to_err_before", 64'(timeout_err), 64'd0);
      end
      if (k == TIMEOUT + 1) begin
        check("to_err_set", 64'(timeout_err), 64'd1);
        check("to_busy_after", 64'(busy), 64'd0);
      end
    end
    check("to_no_words", 64'(words_seen - ws), 64'd0);
    check("to_frame_cnt", 64'(frame_cnt), 64'd5);
    done_en = 1'b1;

    // Next frame completes normally, timeout flag stays sticky
    send_frame(6, IN_BYTES, 1'b0, 1'b1);
    idle_in();
    wait_frames(6);
    check("to_err_sticky", 64'(timeout_err), 64'd1);

    // Abort after byte 1000, then a full frame from address 0
    send_frame(7, 1001, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    abort   = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_s_ready", 64'(s_ready), 64'd1);
    send_frame(8, IN_BYTES, 1'b0, 1'b1);
    idle_in();
    wait_frames(7);
    check("rst_pulses_total", 64'(rst_p), 64'd8);
    check("start_pulses_total", 64'(start_p), 64'd8);

    // Reset during word 4 of the unload
    send_frame(9, IN_BYTES, 1'b0, 1'b1);
    idle_in();
    g = 0;
    while (out_idx != 4 && g < 5000) begin
      @(negedge clk);
      g++;
    end
    check("mid_word_reached", 64'(out_idx), 64'd4);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_m_valid", 64'(m_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_core_rst", 64'(core_rst), 64'd1);
    check("mid_rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("mid_rst_timeout_err", 64'(timeout_err), 64'd0);
    exp_out.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_s_ready", 64'(s_ready), 64'd1);
    check("post_rst_core_rst", 64'(core_rst), 64'd0);
    check("post_rst_wr_queue", 64'(exp_wr.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
